// File: rtl/rr_pop_scheduler.sv
// rtl/rr_pop_scheduler.sv - round-robin burst pop scheduler for four FWFT ingress FIFOs
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   fifo_empty   per-FIFO empty flags, bit i = FIFO i
//   fifo_data_N  FWFT head word of FIFO N, valid while fifo_empty[N] is low
//   pause        downstream back-pressure; no pop while high
//   pop          one-hot combinational read strobe to the granted FIFO
//   data_out     registered forwarded word
//   valid_out    registered qualifier for data_out
//   demux_sel    registered destination field of data_out
//   grant        index of the FIFO currently or last granted
module rr_pop_scheduler #(
    parameter int DATA_W = 10,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        fifo_empty,
    input  logic [DATA_W-1:0] fifo_data_0,
    input  logic [DATA_W-1:0] fifo_data_1,
    input  logic [DATA_W-1:0] fifo_data_2,
    input  logic [DATA_W-1:0] fifo_data_3,
    input  logic              pause,
    output logic [3:0]        pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [1:0]        demux_sel,
    output logic [1:0]        grant
);

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    // Four bits hold BURST-1 for the full legal range 1..15.
    localparam logic [3:0] CNT_LAST = 4'(BURST - 1);

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [1:0]        sel_q, sel_d;

    logic [DATA_W-1:0] head_word;
    logic [1:0]        pick_idx;
    logic              any_ready;
    logic              pop_fire;

    always_comb begin
        head_word = fifo_data_0;
        case (grant_q)
            2'd0:    head_word = fifo_data_0;
            2'd1:    head_word = fifo_data_1;
            2'd2:    head_word = fifo_data_2;
            default: head_word = fifo_data_3;
        endcase
    end

    // Scan from the farthest offset back to ptr so the nearest non-empty
    // FIFO in rotation order is the last (winning) assignment.
    always_comb begin
        logic [1:0] idx;
        pick_idx  = ptr_q;
        any_ready = ~&fifo_empty;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (!fifo_empty[idx]) begin
                pick_idx = idx;
            end
        end
    end

    assign pop_fire = (state_q == SERVE) && !pause && !fifo_empty[grant_q];

    always_comb begin
        pop = 4'b0000;
        if (pop_fire) begin
            pop = 4'b0001 << grant_q;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // Arbitration result is committed here; pause is re-checked in SERVE.
                if (!pause && any_ready) begin
                    grant_d = pick_idx;
                    cnt_d   = 4'd0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (fifo_empty[grant_q]) begin
                    ptr_d   = grant_q + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (pop_fire) begin
                    if (cnt_q == CNT_LAST) begin
                        ptr_d   = grant_q + 2'd1;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = pop_fire;
        if (pop_fire) begin
            data_d = head_word;
            sel_d  = head_word[DATA_W-1 -: 2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            grant_q <= 2'd0;
            cnt_q   <= 4'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign demux_sel = sel_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_rr_pop_scheduler.sv
// tb/tb_rr_pop_scheduler.sv - directed self-checking bench for rr_pop_scheduler
module tb_rr_pop_scheduler;

    logic       clk;
    logic       reset;
    logic       pause;
    logic [3:0] fifo_empty;
    logic [9:0] fd [4];

    logic [3:0] pop_a, pop_b;
    logic [9:0] do_a, do_b;
    logic       vo_a, vo_b;
    logic [1:0] ds_a, ds_b;
    logic [1:0] gr_a, gr_b;

    logic       sel;
    logic [3:0] pop_s;
    logic [9:0] do_s;
    logic       vo_s;
    logic [1:0] ds_s, gr_s;

    logic [3:0] cpop;
    logic [9:0] cdo;
    logic       cvo;
    logic [1:0] cds, cgr;

    logic [9:0] q [4][$];

    int checks;
    int failures;

    rr_pop_scheduler #(.DATA_W(10), .BURST(4)) dut_a (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
        .fifo_data_0(fd[0]), .fifo_data_1(fd[1]), .fifo_data_2(fd[2]), .fifo_data_3(fd[3]),
        .pause(pause), .pop(pop_a), .data_out(do_a), .valid_out(vo_a),
        .demux_sel(ds_a), .grant(gr_a)
    );

    rr_pop_scheduler #(.DATA_W(10), .BURST(1)) dut_b (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
        .fifo_data_0(fd[0]), .fifo_data_1(fd[1]), .fifo_data_2(fd[2]), .fifo_data_3(fd[3]),
        .pause(pause), .pop(pop_b), .data_out(do_b), .valid_out(vo_b),
        .demux_sel(ds_b), .grant(gr_b)
    );

    assign pop_s = sel ? pop_b : pop_a;
    assign do_s  = sel ? do_b  : do_a;
    assign vo_s  = sel ? vo_b  : vo_a;
    assign ds_s  = sel ? ds_b  : ds_a;
    assign gr_s  = sel ? gr_b  : gr_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            fifo_empty[i] = (q[i].size() == 0);
            fd[i]         = (q[i].size() > 0) ? q[i][0] : 10'h000;
        end
    endtask

    // One clock: capture outputs mid-cycle, then retire popped words after the edge.
    task automatic cyc();
        @(negedge clk);
        cpop = pop_s;
        cvo  = vo_s;
        cdo  = do_s;
        cds  = ds_s;
        cgr  = gr_s;
        chk("pop_onehot0", {15'd0, $onehot0(cpop)}, 16'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (cpop[i] && q[i].size() > 0) begin
                void'(q[i].pop_front());
            end
        end
        refresh();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pause = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        refresh();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        reset    = 1'b1;
        pause    = 1'b0;
        for (int i = 0; i < 4; i++) q[i].delete();
        refresh();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_pop_a", {12'd0, pop_a}, 16'h0);
        chk("rst_vo_a", {15'd0, vo_a}, 16'h0);
        chk("rst_do_a", {6'd0, do_a}, 16'h0);
        chk("rst_ds_a", {14'd0, ds_a}, 16'h0);
        chk("rst_gr_a", {14'd0, gr_a}, 16'h0);
        chk("rst_vo_b", {15'd0, vo_b}, 16'h0);
        chk("rst_gr_b", {14'd0, gr_b}, 16'h0);

        // Single queue, BURST=4: 4 pops, IDLE, 2 pops, empty-exit
        @(posedge clk);
        #1;
        do_reset();
        for (int k = 1; k <= 6; k++) q[0].push_back(10'(k));
        refresh();
        for (int c = 0; c < 10; c++) begin
            logic       ev;
            logic [9:0] ed;
            cyc();
            chk($sformatf("t1_pop_c%0d", c), {12'd0, cpop},
                ((c >= 1 && c <= 4) || c == 6 || c == 7) ? 16'h1 : 16'h0);
            ev = 1'b0;
            ed = 10'h0;
            if (c >= 2 && c <= 5) begin ev = 1'b1; ed = 10'(c - 1); end
            if (c == 7 || c == 8) begin ev = 1'b1; ed = 10'(c - 2); end
            chk($sformatf("t1_vo_c%0d", c), {15'd0, cvo}, {15'd0, ev});
            if (ev) chk($sformatf("t1_do_c%0d", c), {6'd0, cdo}, {6'd0, ed});
            if (c == 6) chk("t1_regrant0", {14'd0, cgr}, 16'h0);
        end

        // Rotation, BURST=1: one pop every 2 cycles, grant 0,1,2,3,...
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++) q[i].push_back(10'(i * 16 + k));
        refresh();
        for (int c = 0; c < 17; c++) begin
            int m;
            cyc();
            if (c % 2 == 1) begin
                m = (c - 1) / 2;
                chk($sformatf("t2_pop_c%0d", c), {12'd0, cpop}, 16'(4'b0001 << (m % 4)));
                chk($sformatf("t2_gr_c%0d", c), {14'd0, cgr}, 16'(m % 4));
            end else begin
                chk($sformatf("t2_pop_c%0d", c), {12'd0, cpop}, 16'h0);
                if (c >= 2) begin
                    m = (c - 2) / 2;
                    chk($sformatf("t2_vo_c%0d", c), {15'd0, cvo}, 16'h1);
                    chk($sformatf("t2_do_c%0d", c), {6'd0, cdo}, 16'((m % 4) * 16 + m / 4));
                end
            end
        end
        sel = 1'b0;

        // Skip empties: only FIFO1 and FIFO3 hold data
        do_reset();
        for (int k = 0; k < 8; k++) begin
            q[1].push_back(10'(10'h100 + k));
            q[3].push_back(10'(10'h300 + k));
        end
        refresh();
        for (int c = 0; c < 15; c++) begin
            logic [3:0] ep;
            logic [1:0] eg;
            cyc();
            ep = 4'b0000;
            if (c >= 1 && c <= 4)   ep = 4'b0010;
            if (c >= 6 && c <= 9)   ep = 4'b1000;
            if (c >= 11 && c <= 14) ep = 4'b0010;
            eg = (c >= 6 && c <= 10) ? 2'd3 : 2'd1;
            chk($sformatf("t3_pop_c%0d", c), {12'd0, cpop}, {12'd0, ep});
            if (c >= 1) chk($sformatf("t3_gr_c%0d", c), {14'd0, cgr}, {14'd0, eg});
        end

        // Pause mid-burst on FIFO2
        do_reset();
        for (int k = 1; k <= 4; k++) q[2].push_back(10'(10'h200 + k));
        refresh();
        for (int c = 0; c < 9; c++) begin
            logic       ev;
            logic [9:0] ed;
            pause = (c >= 3 && c <= 5);
            cyc();
            chk($sformatf("t4_pop_c%0d", c), {12'd0, cpop},
                (c == 1 || c == 2 || c == 6 || c == 7) ? 16'h4 : 16'h0);
            ev = 1'b0;
            ed = 10'h0;
            case (c)
                2: begin ev = 1'b1; ed = 10'h201; end
                3: begin ev = 1'b1; ed = 10'h202; end
                7: begin ev = 1'b1; ed = 10'h203; end
                8: begin ev = 1'b1; ed = 10'h204; end
                default: ev = 1'b0;
            endcase
            chk($sformatf("t4_vo_c%0d", c), {15'd0, cvo}, {15'd0, ev});
            if (ev) chk($sformatf("t4_do_c%0d", c), {6'd0, cdo}, {6'd0, ed});
            if (c == 5) chk("t4_gr_held", {14'd0, cgr}, 16'h2);
        end
        pause = 1'b0;
        chk("t4_fifo2_drained", 16'(q[2].size()), 16'h0);

        // Demux select from destination field
        do_reset();
        q[0].push_back(10'h0FF);
        q[0].push_back(10'h1FF);
        q[0].push_back(10'h2FF);
        q[0].push_back(10'h3FF);
        refresh();
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (c >= 2) begin
                chk($sformatf("t5_vo_c%0d", c), {15'd0, cvo}, 16'h1);
                chk($sformatf("t5_ds_c%0d", c), {14'd0, cds}, 16'(c - 2));
                chk($sformatf("t5_do_c%0d", c), {6'd0, cdo}, 16'(10'h0FF + (c - 2) * 256));
            end
        end

        // Reset mid-burst; first push ptr to 3 via a FIFO2 burst
        do_reset();
        for (int k = 1; k <= 4; k++) q[2].push_back(10'(10'h200 + k));
        refresh();
        for (int c = 0; c < 6; c++) cyc();
        for (int k = 1; k <= 6; k++) q[1].push_back(10'(10'h300 + k));
        refresh();
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (c >= 1) chk($sformatf("t6_pre_pop_c%0d", c), {12'd0, cpop}, 16'h2);
        end
        chk("t6_pre_vo", {15'd0, vo_a}, 16'h1);
        chk("t6_pre_ds", {14'd0, ds_a}, 16'h3);
        reset = 1'b1;
        #1;
        chk("t6_rst_vo", {15'd0, vo_a}, 16'h0);
        chk("t6_rst_do", {6'd0, do_a}, 16'h0);
        chk("t6_rst_ds", {14'd0, ds_a}, 16'h0);
        chk("t6_rst_gr", {14'd0, gr_a}, 16'h0);
        chk("t6_rst_pop", {12'd0, pop_a}, 16'h0);
        for (int k = 1; k <= 4; k++) q[3].push_back(10'(10'h0A0 + k));
        refresh();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (c == 1) begin
                chk("t6_post_gr", {14'd0, cgr}, 16'h1);
                chk("t6_post_pop", {12'd0, cpop}, 16'h2);
            end
            if (c == 2) begin
                chk("t6_post_vo", {15'd0, cvo}, 16'h1);
                chk("t6_post_do", {6'd0, cdo}, 16'h303);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_pop_scheduler.md
# rr_pop_scheduler

Round-robin scheduler that drains four first-word-fall-through input FIFOs into the shared 10-bit path feeding the 4-way demultiplexer stage. It grants one FIFO at a time and pops up to BURST words per grant before rotating. It stalls on downstream pause and forwards each word, registered, together with the demux select taken from the word's destination field. It sits between the ingress FIFOs and the demux in the complete module.

## Interface
- DATA_W, 10, word width; bits [DATA_W-1:DATA_W-2] are the destination field
- BURST, 4, maximum consecutive pops per grant; legal range 1..15

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- fifo_empty  in  4  empty flag per input FIFO, bit i = FIFO i
- fifo_data_0 .. fifo_data_3  in  DATA_W each  head word of FIFO i, valid whenever ~fifo_empty[i] (FWFT)
- pause  in  1  downstream full or almost-full; no pop while high
- pop  out  4  one-hot read strobe to FIFO i; at most one bit high
- data_out  out  DATA_W  forwarded word, registered
- valid_out  out  1  data_out qualifier, registered
- demux_sel  out  2  destination field of data_out, drives demux select, registered
- grant  out  2  index of FIFO currently or last granted

## Operation
- Registers: state {IDLE, SERVE}, ptr[1:0] (rotation start), grant[1:0], cnt (width to hold BURST-1), output regs.
- Reset values: state=IDLE, ptr=0, grant=0, cnt=0, data_out=0, valid_out=0, demux_sel=0. pop=0, since it is combinational from state.
- IDLE: if ~pause and any ~fifo_empty, pick the first non-empty index scanning ptr, ptr+1, ... mod 4. Load grant, set cnt=0, go to SERVE. No pop in IDLE. Otherwise stay in IDLE.
- SERVE: combinational pop[grant] = ~pause & ~fifo_empty[grant]. All other pop bits are 0.
- On a pop cycle, when cnt==BURST-1: set ptr=grant+1 (wraps 3->0), cnt=0, go to IDLE. Otherwise cnt+=1 and stay in SERVE.
- SERVE with fifo_empty[grant]=1 (and no pop): set ptr=grant+1, cnt=0, go to IDLE. This applies regardless of pause.
- SERVE with pause=1 and FIFO non-empty: hold state; cnt and grant unchanged.
- Datapath: on a pop cycle, data_out <= fifo_data_[grant], demux_sel <= fifo_data_[grant][DATA_W-1:DATA_W-2], valid_out <= 1. Otherwise valid_out <= 0 and data_out/demux_sel hold.
- BURST=1 gives pure round robin at one word per grant.
- pause does not block the IDLE->SERVE arbitration result once taken; pause is sampled again in SERVE.

## Timing
- Arbitration costs one IDLE cycle per grant change. Peak throughput is BURST words per BURST+1 cycles.
- Pop-to-output latency is 1 cycle: word popped at edge N appears with valid_out at N+1.
- pop is combinational and depends on fifo_empty and pause in the same cycle; there are no registered paths from pop back to its inputs.
- Last word of a queue popped before BURST is reached: the next cycle sees empty, goes to IDLE, and ptr advances, so one extra non-popping cycle occurs.
- Asynchronous reset mid-burst: outputs clear immediately. In-flight valid_out drops and no partial word is re-emitted. The FIFO keeps the words not yet popped.
- Fairness: every non-empty FIFO is granted within 3 grants of becoming non-empty.

## Test plan
- Single queue: FIFO0 holds 6 words 0x001..0x006, others empty, BURST=4. Expected: pop[0] for 4 consecutive cycles, 1 IDLE cycle, grant=0 again, 2 pops. valid_out sequence is 0x001..0x006, each 1 cycle after its pop.
- Rotation: all FIFOs hold 8 words, BURST=1. Expected grant order 0,1,2,3,0,1,... with one pop every 2 cycles and pop always one-hot.
- Skip empties: only FIFO1 and FIFO3 non-empty, ptr=0. Expected: grant=1 for BURST pops, then grant=3, then grant=1. FIFO0 and FIFO2 never popped.
- Pause mid-burst: FIFO2 has 4 words, pause high for 3 cycles after the 2nd pop. Expected: pop=0 and valid_out=0 during the pause, cnt held. Remaining 2 words popped after pause drops, no duplication or loss.
- Demux select: FIFO0 head words 0x0FF, 0x1FF, 0x2FF, 0x3FF. Expected demux_sel = 0,1,2,3 on successive valid_out cycles.
- Reset mid-burst: assert reset asynchronously after 2 pops from FIFO1. Expected: all outputs 0 immediately; after release, arbitration restarts at ptr=0.
